// File: rtl/cpu6502_pkg.sv
// cpu6502_pkg: opcodes, FSM states and ALU operations shared by cpu6502_lite
package cpu6502_pkg;
    typedef enum logic [2:0] {FETCH, OPER_LO, OPER_HI, MEM, HALT} state_t;
    typedef enum logic {ALU_LDA, ALU_ADC} alu_op_t;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_NOP     = 8'hEA;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    function automatic logic is_supported(input logic [7:0] op);
        return op inside {OP_LDA_IMM, OP_ADC_IMM, OP_NOP, OP_JMP_ABS, OP_LDA_ABS, OP_STA_ABS};
    endfunction
endpackage

// File: rtl/cpu6502_alu.sv
// cpu6502_alu: combinational load/add-with-carry datapath with N/Z/C generation
module cpu6502_alu
    import cpu6502_pkg::*;
(
    input  alu_op_t    op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] result,
    output logic       n,
    output logic       z,
    output logic       c
);
    logic [8:0] sum;
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b} + {8'd0, c_in};
        result = (op == ALU_ADC) ? sum[7:0] : b;
        c      = (op == ALU_ADC) ? sum[8] : c_in;
        n      = result[7];
        z      = (result == 8'd0);
    end
endmodule

// File: rtl/cpu6502_lite.sv
// cpu6502_lite: tiny 6502 subset core; one bus cycle per clock, rdy=0 freezes everything
module cpu6502_lite
    import cpu6502_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              rw,
    input  logic              rdy,
    output logic [7:0]        acc,
    output logic [2:0]        flags,
    output logic              halted
);
    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [7:0]        opcode;
    logic [7:0]        adl;
    logic [7:0]        alu_res;
    logic              alu_n;
    logic              alu_z;
    logic              alu_c;

    assign pc_inc = pc + ADDR_W'(1);
    // the high address byte is consumed straight off the bus in OPER_HI
    assign target = ADDR_W'({data_in, adl});

    cpu6502_alu u_alu (
        .op    ((opcode == OP_ADC_IMM) ? ALU_ADC : ALU_LDA),
        .a     (acc),
        .b     (data_in),
        .c_in  (flags[0]),
        .result(alu_res),
        .n     (alu_n),
        .z     (alu_z),
        .c     (alu_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_VEC;
            addr     <= RESET_VEC;
            rw       <= 1'b1;
            data_out <= 8'd0;
            acc      <= 8'd0;
            flags    <= 3'd0;
            halted   <= 1'b0;
            opcode   <= 8'd0;
            adl      <= 8'd0;
        end else if (rdy) begin
            case (state)
                FETCH: begin
                    opcode <= data_in;
                    pc     <= pc_inc;
                    addr   <= pc_inc;
                    state  <= is_supported(data_in) ? OPER_LO : HALT;
                    halted <= !is_supported(data_in);
                end
                OPER_LO: begin
                    if (opcode == OP_NOP) begin
                        state <= FETCH;
                    end else if (opcode == OP_LDA_IMM || opcode == OP_ADC_IMM) begin
                        acc   <= alu_res;
                        flags <= {alu_n, alu_z, alu_c};
                        pc    <= pc_inc;
                        addr  <= pc_inc;
                        state <= FETCH;
                    end else begin
                        adl   <= data_in;
                        pc    <= pc_inc;
                        addr  <= pc_inc;
                        state <= OPER_HI;
                    end
                end
                OPER_HI: begin
                    if (opcode == OP_JMP_ABS) begin
                        pc    <= target;
                        addr  <= target;
                        state <= FETCH;
                    end else begin
                        pc       <= pc_inc;
                        addr     <= target;
                        rw       <= (opcode != OP_STA_ABS);
                        data_out <= (opcode == OP_STA_ABS) ? acc : 8'd0;
                        state    <= MEM;
                    end
                end
                MEM: begin
                    if (opcode == OP_LDA_ABS) begin
                        acc   <= alu_res;
                        flags <= {alu_n, alu_z, alu_c};
                    end
                    addr     <= pc;
                    rw       <= 1'b1;
                    data_out <= 8'd0;
                    state    <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu6502_lite.sv
// tb_cpu6502_lite: instruction-level reference model feeds a bus-cycle scoreboard
module tb_cpu6502_lite;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy = 1'b1;
    logic        rw;
    logic        halted;
    logic [11:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  acc;
    logic [2:0]  flags;

    logic [7:0] mem [4096];
    logic [7:0] wr_mem [4096];
    int         wr_tag [4096];
    logic [7:0] m_mem [4096];
    int phase = 0;
    int n_checks = 0;
    int n_fail = 0;
    int pops = 0;
    int hold = 0;
    bit rand_rdy = 1'b0;
    int m_pc, m_acc, m_n, m_z, m_c, m_halt;

    typedef struct {
        logic [11:0] addr;
        logic        rw;
        logic [7:0]  dout;
        logic [7:0]  acc;
        logic [2:0]  flags;
        logic        halted;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    cpu6502_lite #(.ADDR_W(12), .RESET_VEC(12'h000)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .rw      (rw),
        .rdy     (rdy),
        .acc     (acc),
        .flags   (flags),
        .halted  (halted)
    );

    // bytes written by the DUT in the current phase shadow the preloaded image
    assign data_in = (wr_tag[addr] == phase) ? wr_mem[addr] : mem[addr];

    always @(posedge clk)
        if (!reset && rdy && !rw) begin
            wr_mem[addr] <= data_out;
            wr_tag[addr] <= phase;
        end

    always @(posedge clk) begin
        #2;
        if (reset) rdy = 1'b1;
        else if (hold > 0) begin
            rdy = 1'b0;
            hold--;
        end else rdy = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
    end

    function automatic logic [7:0] rd(input int a);
        return (wr_tag[a] == phase) ? wr_mem[a] : mem[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (!reset && q.size() > 0) begin
            exp_t e;
            e = q[0];
            chk("addr", 32'(addr), 32'(e.addr));
            chk("rw", 32'(rw), 32'(e.rw));
            chk("data_out", 32'(data_out), 32'(e.dout));
            chk("acc", 32'(acc), 32'(e.acc));
            chk("flags", 32'(flags), 32'(e.flags));
            chk("halted", 32'(halted), 32'(e.halted));
            if (rdy) begin
                void'(q.pop_front());
                pops++;
            end
        end

    task automatic push(input int a, input int w, input int d);
        exp_t e;
        e.addr   = a[11:0];
        e.rw     = w[0];
        e.dout   = d[7:0];
        e.acc    = m_acc[7:0];
        e.flags  = {m_n[0], m_z[0], m_c[0]};
        e.halted = m_halt[0];
        q.push_back(e);
    endtask

    task automatic set_nz();
        m_z = (m_acc == 0);
        m_n = (m_acc >= 128);
    endtask

    // executes n instructions from address 0, emitting every expected bus cycle
    task automatic model_run(input int n, input int halt_cycles);
        m_pc = 0; m_acc = 0; m_n = 0; m_z = 0; m_c = 0; m_halt = 0;
        for (int k = 0; k < n && m_halt == 0; k++) begin
            int op, lo, hi, ea, s;
            op = m_mem[m_pc];
            push(m_pc, 1, 0);
            m_pc = (m_pc + 1) % 4096;
            if (op == 'hA9 || op == 'h69) begin
                push(m_pc, 1, 0);
                lo = m_mem[m_pc];
                m_pc = (m_pc + 1) % 4096;
                if (op == 'hA9) m_acc = lo;
                else begin
                    s = m_acc + lo + m_c;
                    m_c = (s > 255);
                    m_acc = s % 256;
                end
                set_nz();
            end else if (op == 'hEA) begin
                push(m_pc, 1, 0);
            end else if (op == 'h4C || op == 'hAD || op == 'h8D) begin
                push(m_pc, 1, 0);
                lo = m_mem[m_pc];
                m_pc = (m_pc + 1) % 4096;
                push(m_pc, 1, 0);
                hi = m_mem[m_pc];
                ea = (hi * 256 + lo) % 4096;
                if (op == 'h4C) m_pc = ea;
                else begin
                    m_pc = (m_pc + 1) % 4096;
                    if (op == 'hAD) begin
                        push(ea, 1, 0);
                        m_acc = m_mem[ea];
                        set_nz();
                    end else begin
                        push(ea, 0, m_acc);
                        m_mem[ea] = m_acc[7:0];
                    end
                end
            end else begin
                m_halt = 1;
                for (int h = 0; h < halt_cycles; h++) push(m_pc, 1, 0);
            end
        end
    endtask

    task automatic begin_phase();
        reset = 1'b1;
        rand_rdy = 1'b0;
        hold = 0;
        q.delete();
        pops = 0;
        phase++;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic go(input int n, input int halt_cycles, input bit rr);
        for (int i = 0; i < 4096; i++) m_mem[i] = mem[i];
        model_run(n, halt_cycles);
        rand_rdy = rr;
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic finish_phase();
        drain();
        @(posedge clk);
        #1;
        chk("final_acc", 32'(acc), 32'(m_acc[7:0]));
        chk("final_flags", 32'(flags), 32'({m_n[0], m_z[0], m_c[0]}));
    endtask

    initial begin
        logic [7:0] ops [6] = '{8'hA9, 8'h69, 8'hEA, 8'h4C, 8'hAD, 8'h8D};
        int cyc;
        begin_phase();
        chk("rst_addr", 32'(addr), 0);
        chk("rst_rw", 32'(rw), 1);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_flags", 32'(flags), 0);
        chk("rst_halted", 32'(halted), 0);

        begin_phase();
        mem[0] = 8'hA9; mem[1] = 8'h00;
        go(1, 0, 1'b0);
        finish_phase();
        chk("lda0_flags", 32'(flags), 32'h2);
        chk("lda0_addr", 32'(addr), 2);

        begin_phase();
        mem[0] = 8'hA9; mem[1] = 8'hFF; mem[2] = 8'h69; mem[3] = 8'h01; mem[4] = 8'h69; mem[5] = 8'h00;
        go(3, 0, 1'b1);
        finish_phase();
        chk("adc_acc", 32'(acc), 1);
        chk("adc_flags", 32'(flags), 0);

        begin_phase();
        mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'h8D; mem[3] = 8'h34; mem[4] = 8'h12;
        go(2, 0, 1'b0);
        finish_phase();
        chk("sta_mem", 32'(rd('h234)), 32'h5A);

        begin_phase();
        mem[0] = 8'h4C; mem[1] = 8'hFE; mem[2] = 8'h0F;
        mem[12'hFFE] = 8'h4C; mem[12'hFFF] = 8'h00;
        mem[12'hC00] = 8'h4C; mem[12'hC01] = 8'h34; mem[12'hC02] = 8'h12;
        mem[12'h234] = 8'hA9; mem[12'h235] = 8'h77;
        go(4, 0, 1'b1);
        finish_phase();
        chk("jmp_acc", 32'(acc), 32'h77);

        begin_phase();
        mem[0] = 8'hAD; mem[1] = 8'h00; mem[2] = 8'h03; mem[12'h300] = 8'hC3;
        go(1, 0, 1'b0);
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
            if (cyc == 2) hold = 3;
        end
        chk("stall_cycles", cyc, 7);
        finish_phase();
        chk("stall_acc", 32'(acc), 32'hC3);

        for (int r = 0; r < 8; r++) begin
            begin_phase();
            for (int i = 0; i < 4096; i++)
                mem[i] = ($urandom_range(99) < 85) ? ops[$urandom_range(5)] : 8'($urandom);
            go(40, 3, 1'b1);
            finish_phase();
        end

        begin_phase();
        mem[0] = 8'hA9; mem[1] = 8'h3C; mem[2] = 8'hFF;
        go(2, 6, 1'b1);
        finish_phase();
        chk("ill_halted", 32'(halted), 1);
        chk("ill_addr", 32'(addr), 3);

        begin_phase();
        mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'h8D; mem[3] = 8'h34; mem[4] = 8'h02;
        mem[12'h234] = 8'h11;
        go(2, 0, 1'b0);
        drain();
        chk("abort_rw_low", 32'(rw), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rw", 32'(rw), 1);
        chk("abort_dout", 32'(data_out), 0);
        chk("abort_halted", 32'(halted), 0);
        chk("abort_addr", 32'(addr), 0);
        chk("abort_mem", 32'(rd('h234)), 32'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu6502_lite.md
CPU6502_LITE -- requirements
Module: cpu6502_lite

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address bus width (12..16).
REQ-002 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset (ADDR_W bits).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port addr, output, ADDR_W, bus address, registered.
REQ-006 SHALL have port data_in, input, 8, read data, valid in the same cycle addr is driven (combinational memory).
REQ-007 SHALL have port data_out, output, 8, write data, valid while rw=0.
REQ-008 SHALL have port rw, output, 1, 1=read, 0=write.
REQ-009 SHALL have port rdy, input, 1, wait request; 0 stalls the current bus cycle.
REQ-010 SHALL have port acc, output, 8, accumulator value.
REQ-011 SHALL have port flags, output, 3, {N,Z,C}.
REQ-012 SHALL have port halted, output, 1, set after an unsupported opcode.

Function
REQ-013 SHALL implement states FETCH, OPER_LO, OPER_HI, MEM, HALT.
REQ-014 SHALL complete one bus cycle per clock with rdy=1; with rdy=0 SHALL hold every register and output unchanged.
REQ-015 FETCH SHALL drive addr=PC, rw=1, latch opcode from data_in, PC+1; go OPER_LO if supported, else HALT.
REQ-016 Supported opcodes SHALL be A9 LDA#, 69 ADC#, EA NOP, 4C JMP abs, AD LDA abs, 8D STA abs.
REQ-017 OPER_LO SHALL read addr=PC, PC+1; A9: acc=data_in; 69: acc=acc+data_in+C; EA: discard data, do not increment PC; these return to FETCH.
REQ-018 OPER_LO for 4C/AD/8D SHALL latch adl=data_in, go OPER_HI.
REQ-019 OPER_HI SHALL read addr=PC, latch adh; 4C: PC={adh,adl} truncated to ADDR_W, go FETCH; AD/8D: PC+1, go MEM.
REQ-020 MEM SHALL drive addr={adh,adl}[ADDR_W-1:0]; AD: rw=1, acc=data_in; 8D: rw=0, data_out=acc; then FETCH.
REQ-021 Cycle counts (rdy=1) SHALL be: LDA#/ADC#/NOP 2, JMP 3, LDA abs/STA abs 4.
REQ-022 LDA SHALL set Z=(result==0), N=result[7], C unchanged; ADC SHALL set C=carry-out of 9-bit sum, Z, N; STA/JMP/NOP SHALL leave flags.
REQ-023 PC SHALL wrap modulo 2^ADDR_W (e.g. max+1 -> 0).
REQ-024 HALT SHALL hold PC, acc, flags; rw=1, halted=1; exit only via reset.
REQ-025 rw SHALL be 0 only during a MEM cycle of 8D; at all other times rw=1.
REQ-026 data_out SHALL be 0 whenever rw=1.

Reset
REQ-027 On reset=1 at a clk edge: PC=RESET_VEC, state=FETCH, acc=0, flags=0, addr=RESET_VEC, rw=1, data_out=0, halted=0, opcode/adl/adh=0.
REQ-028 reset SHALL take priority over rdy and abort any instruction mid-execution, including an in-progress write.
REQ-029 First fetch after reset release SHALL occur at RESET_VEC on the first clock with reset=0 and rdy=1.

Structure
REQ-030 Opcode constants and state encodings SHALL live in shared package cpu6502_pkg.
REQ-031 Arithmetic and flag generation SHALL be a sub-module cpu6502_alu (combinational: op, a, b, c_in -> result, N, Z, C).
REQ-032 Top level SHALL contain FSM, PC, operand latches and bus drive only.

Verification
REQ-033 LDA#: mem[0]=A9,mem[1]=00 -> after 2 cycles acc=00, Z=1, N=0, addr reaches 0002.
REQ-034 ADC carry: A9 FF, 69 01 -> acc=00, C=1, Z=1; then 69 00 -> acc=01, C=0.
REQ-035 STA abs: A9 5A, 8D 34 12 -> in MEM cycle addr=1234, rw=0, data_out=5A exactly one cycle.
REQ-036 JMP + wrap: ADDR_W=12, PC at FFE with 4C 00 00 ... -> PC wraps to 000; JMP to 0x1234 yields addr=234.
REQ-037 rdy stall: rdy=0 for 3 cycles during OPER_HI of AD -> addr/state/acc frozen, instruction completes 3 cycles late with correct acc.
REQ-038 Illegal + reset: opcode FF -> halted=1, addr static; assert reset mid-STA -> no write after reset, halted=0, addr=RESET_VEC.
